// File: rtl/pixel_packer.sv
// pixel_packer: packs 24-bit RGB pixels into 32-bit AXI-Stream words through
// an 8-entry byte FIFO. Frame markers ride along per byte: SOF becomes tuser
// and EOL becomes tlast. Each EOL pads the stream out to a word boundary.
module pixel_packer #(
    parameter logic [7:0] PAD_VALUE = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] in_pixel,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sof,
    input  logic        in_eol,
    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tlast,
    output logic        out_stream_tuser,
    output logic        out_stream_tvalid,
    input  logic        out_stream_tready,
    output logic        err_misaligned
);

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 4;
    localparam int unsigned IW    = 3;

    logic [7:0]       fdata  [DEPTH];
    logic [7:0]       n_data [DEPTH];
    logic [DEPTH-1:0] fkeep, fuser, flast;
    logic [DEPTH-1:0] n_keep, n_user, n_last;
    logic [CW-1:0]    count, n_count, pos, end_cnt;
    logic             n_err, n_tvalid, n_tlast, n_tuser;
    logic             pop, push;

    // Back-pressure: room for a full pixel plus padding, or a pop frees 4 bytes this cycle
    assign in_ready = (count <= CW'(5)) || out_stream_tready;
    assign pop      = out_stream_tvalid && out_stream_tready;
    assign push     = in_valid && in_ready;

    // The output word is always the bottom four FIFO entries
    assign out_stream_tdata = {fdata[3], fdata[2], fdata[1], fdata[0]};
    assign out_stream_tkeep = fkeep[3:0];

    // Next FIFO contents: shift out a word first, then append at the post-pop position
    always_comb begin
        n_data  = fdata;
        n_keep  = fkeep;
        n_user  = fuser;
        n_last  = flast;
        n_count = count;
        n_err   = err_misaligned;
        end_cnt = '0;

        if (pop) begin
            for (int i = 0; i < 4; i++) begin
                n_data[i] = fdata[i + 4];
                n_keep[i] = fkeep[i + 4];
                n_user[i] = fuser[i + 4];
                n_last[i] = flast[i + 4];
            end
            for (int i = 4; i < int'(DEPTH); i++) begin
                n_data[i] = 8'h00;
                n_keep[i] = 1'b0;
                n_user[i] = 1'b0;
                n_last[i] = 1'b0;
            end
            n_count = count - CW'(4);
        end

        pos = n_count;

        if (push) begin
            n_data[pos[IW-1:0]]           = in_pixel[7:0];
            n_keep[pos[IW-1:0]]           = 1'b1;
            n_user[pos[IW-1:0]]           = in_sof;
            n_last[pos[IW-1:0]]           = 1'b0;
            n_data[IW'(pos + CW'(1))]     = in_pixel[15:8];
            n_keep[IW'(pos + CW'(1))]     = 1'b1;
            n_user[IW'(pos + CW'(1))]     = 1'b0;
            n_last[IW'(pos + CW'(1))]     = 1'b0;
            n_data[IW'(pos + CW'(2))]     = in_pixel[23:16];
            n_keep[IW'(pos + CW'(2))]     = 1'b1;
            n_user[IW'(pos + CW'(2))]     = 1'b0;
            n_last[IW'(pos + CW'(2))]     = in_eol;

            end_cnt = pos + CW'(3);
            if (in_eol) begin
                end_cnt = (end_cnt + CW'(3)) & ~CW'(3);
            end

            // Padding bytes close the line's final word
            for (int j = 0; j < int'(DEPTH); j++) begin
                if ((CW'(j) >= pos + CW'(3)) && (CW'(j) < end_cnt)) begin
                    n_data[j] = PAD_VALUE;
                    n_keep[j] = 1'b0;
                    n_user[j] = 1'b0;
                    n_last[j] = 1'b0;
                end
            end

            n_count = end_cnt;
            if (in_sof && (pos[1:0] != 2'b00)) begin
                n_err = 1'b1;
            end
        end

        n_tvalid = (n_count >= CW'(4));
        n_tlast  = |n_last[3:0];
        n_tuser  = |n_user[3:0];
    end

    // FIFO state and registered stream flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fdata[i] <= 8'h00;
            end
            fkeep             <= '0;
            fuser             <= '0;
            flast             <= '0;
            count             <= '0;
            err_misaligned    <= 1'b0;
            out_stream_tvalid <= 1'b0;
            out_stream_tlast  <= 1'b0;
            out_stream_tuser  <= 1'b0;
        end else begin
            fdata             <= n_data;
            fkeep             <= n_keep;
            fuser             <= n_user;
            flast             <= n_last;
            count             <= n_count;
            err_misaligned    <= n_err;
            out_stream_tvalid <= n_tvalid;
            out_stream_tlast  <= n_tlast;
            out_stream_tuser  <= n_tuser;
        end
    end

endmodule
